ov7670_reg_sequencer: RTL
=========================

OV7670_REG_SEQUENCER -- requirements
Module: ov7670_reg_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, the number of cameras programmed in sequence.
REQ-002 SHALL have parameter ROM_AW, default 8, the table address width (table depth 2**ROM_AW).
REQ-003 SHALL have parameter TICKS_PER_MS, default 25000, the clk cycles per millisecond of delay.
REQ-004 SHALL derive CH_W = max(1, clog2(CHANNELS)).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle pulse; begins a full programming run.
REQ-008 rom_addr  out  ROM_AW  table read address.
REQ-009 rom_data  in  16  table word, valid 1 cycle after rom_addr is presented (registered ROM).
REQ-010 cmd_valid  out  1  {reg,value} command offered to the SCCB master.
REQ-011 cmd_ready  in  1  SCCB master accepts the command this cycle.
REQ-012 cmd_data  out  16  [15:8] register, [7:0] value.
REQ-013 cmd_chan  out  CH_W  camera index the command targets.
REQ-014 busy  out  1  run in progress.
REQ-015 done  out  CHANNELS  per-camera completion flags.
REQ-016 err  out  1  table overran without an end marker.

Function
REQ-017 Table word 16'hFFFF SHALL be the end marker.
REQ-018 Table word 16'hF0nn SHALL be a delay entry of nn ms (nn=0 means no wait); it SHALL never be issued as a command.
REQ-019 Every other table word SHALL be issued verbatim as cmd_data.
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT_ROM, DECODE, ISSUE, DELAY, NEXT_CH, FINISH, ERROR.
REQ-021 IDLE: on start, SHALL set busy=1, channel=0, rom_addr=0, clear done and err, then go to FETCH.
REQ-022 FETCH -> WAIT_ROM -> DECODE SHALL take exactly 2 cycles, to honour the ROM latency.
REQ-023 DECODE SHALL go to NEXT_CH on an end marker, to DELAY on a delay entry, and to ISSUE otherwise.
REQ-024 ISSUE SHALL hold cmd_valid=1 with cmd_data and cmd_chan stable until cmd_ready=1.
REQ-025 On the ISSUE handshake cycle the block SHALL drop cmd_valid the next cycle, increment rom_addr and go to FETCH.
REQ-026 cmd_ready while cmd_valid=0 SHALL be ignored.
REQ-027 DELAY SHALL count nn*TICKS_PER_MS cycles using a counter of at least 8+clog2(TICKS_PER_MS) bits, then increment rom_addr and go to FETCH.
REQ-028 NEXT_CH SHALL set done[channel]=1.
REQ-029 From NEXT_CH, if channel < CHANNELS-1 the block SHALL increment channel, set rom_addr=0 and go to FETCH; otherwise it SHALL go to FINISH.
REQ-030 FINISH SHALL set busy=0 and go to IDLE; done SHALL persist until the next start or reset.
REQ-031 Address wrap-around: if rom_addr = 2**ROM_AW-1 and that word is not an end marker, the block SHALL go to ERROR after handling the word, with no wrap to 0.
REQ-032 ERROR SHALL set err=1, busy=0 and cmd_valid=0, and SHALL leave only on start or reset.
REQ-033 start while busy=1 SHALL be ignored.
REQ-034 A start arriving in the same cycle as FINISH SHALL be ignored (block not yet IDLE).
REQ-035 A start arriving in ERROR SHALL restart the run as from IDLE.

Reset
REQ-036 With rst_n=0 the block SHALL force state IDLE, rom_addr=0, cmd_valid=0, cmd_data=0, cmd_chan=0, busy=0, done=0, err=0, and clear the delay counter.
REQ-037 Reset mid-handshake or mid-delay SHALL abort immediately with no further command issued.
REQ-038 Deassertion SHALL take effect on the next rising clk edge; no start SHALL be sampled in that first cycle.

Verification
REQ-039 Table {1280,F00A,1200,FFFF}, CHANNELS=2, TICKS_PER_MS=4, cmd_ready tied 1 -> commands 1280,1200 on chan 0 then 1280,1200 on chan 1; a 40-cycle gap after each 1280; done=2'b11; busy=0.
REQ-040 Same table, cmd_ready held 0 for 10 cycles -> cmd_valid=1 and cmd_data=1280 stable all 10 cycles; exactly one transfer occurs.
REQ-041 ROM_AW=2, table {1100,1200,1300,1400} (no end marker) -> 4 commands issued, then err=1, busy=0, done=0.
REQ-042 rst_n pulsed low during DELAY -> all outputs at reset values; the next start reissues from address 0 on chan 0.
REQ-043 start pulsed again while busy -> command stream unchanged, same total count.
REQ-044 Table {F000,FFFF} -> no cmd_valid; done=all-ones within 10 cycles per channel.

Source files
------------

// File: rtl/ov7670_reg_sequencer_if.sv
// ov7670_reg_sequencer_if
//   Command channel between the register sequencer and an SCCB master.
//   master modport: drives cmd_valid / cmd_data / cmd_chan, samples cmd_ready.
//   slave modport : samples the command, drives cmd_ready.
//   cmd_data[15:8] is the camera register, cmd_data[7:0] the value to write.
interface ov7670_reg_sequencer_if #(
    parameter int unsigned CHANNELS = 2
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [15:0]     cmd_data;
    logic [CH_W-1:0] cmd_chan;

    modport master (
        output cmd_valid,
        output cmd_data,
        output cmd_chan,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  cmd_chan,
        output cmd_ready
    );
endinterface

// File: rtl/ov7670_reg_sequencer.sv
// ov7670_reg_sequencer
//   Walks a register table once per camera and hands each {reg,value} word to an
//   SCCB master. 16'hFFFF ends a camera's table, 16'hF0nn waits nn milliseconds,
//   anything else is issued verbatim on cmd_chan = current camera.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse that begins a full run (ignored while busy)
//   rom_addr    table read address; rom_data arrives one cycle later (registered ROM)
//   cmd         command channel (master side)
//   busy        run in progress
//   done        per-camera completion flags, held until the next start or reset
//   err         table ran off its last address without an end marker
module ov7670_reg_sequencer #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned ROM_AW       = 8,
    parameter int unsigned TICKS_PER_MS = 25000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [15:0]            rom_data,
    ov7670_reg_sequencer_if.master cmd,
    output logic                   busy,
    output logic [CHANNELS-1:0]    done,
    output logic                   err
);
    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // 8 bits for nn plus enough to hold TICKS_PER_MS; 255*T always fits
    localparam int unsigned CNT_W = 8 + $clog2(TICKS_PER_MS);
    localparam logic [ROM_AW-1:0] ADDR_LAST = {ROM_AW{1'b1}};
    localparam logic [CH_W-1:0]   CHAN_LAST = CH_W'(CHANNELS - 1);

    typedef enum logic [3:0] {
        StIdle, StFetch, StWaitRom, StDecode, StIssue,
        StDelay, StNextCh, StFinish, StError
    } state_e;

    state_e              state_q, state_d;
    logic [ROM_AW-1:0]   addr_q, addr_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [15:0]         cmd_data_q, cmd_data_d;
    logic                busy_q, busy_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic                err_q, err_d;
    // Low for the first cycle after reset release so a start there is not taken
    logic                armed_q;
    logic                advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            chan_q      <= '0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= '0;
            err_q       <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            armed_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        chan_d      = chan_q;
        cnt_d       = cnt_q;
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        advance     = 1'b0;

        case (state_q)
            StIdle, StError: begin
                if (start && armed_q) begin
                    busy_d  = 1'b1;
                    chan_d  = '0;
                    addr_d  = '0;
                    done_d  = '0;
                    err_d   = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch:   state_d = StWaitRom;
            StWaitRom: state_d = StDecode;
            StDecode: begin
                if (rom_data == 16'hFFFF) begin
                    state_d = StNextCh;
                end else if (rom_data[15:8] == 8'hF0) begin
                    cnt_d   = CNT_W'(rom_data[7:0]) * CNT_W'(TICKS_PER_MS);
                    state_d = StDelay;
                end else begin
                    cmd_data_d  = rom_data;
                    cmd_valid_d = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (cmd.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    advance     = 1'b1;
                end
            end
            StDelay: begin
                // A loaded count of N occupies exactly N cycles here (0 and 1 both take one)
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StNextCh: begin
                done_d[chan_q] = 1'b1;
                if (chan_q < CHAN_LAST) begin
                    chan_d  = chan_q + CH_W'(1);
                    addr_d  = '0;
                    state_d = StFetch;
                end else begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Moving past the last table slot without an end marker is a table fault
        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = StError;
            end else begin
                addr_d  = addr_q + ROM_AW'(1);
                state_d = StFetch;
            end
        end
    end

    assign rom_addr      = addr_q;
    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_data  = cmd_data_q;
    assign cmd.cmd_chan  = chan_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule
